// File: rtl/data_mem_resp_if.sv
// data_mem_resp_if: CPU data-memory port bundle.
//   DM_CS/DM_R/DM_W : access select, read request, write request
//   addr            : byte address
//   dm_in           : write data (CPU -> memory)
//   dm_out          : read data (memory -> CPU), combinational
// master = CPU side, slave = memory responder side.
interface data_mem_resp_if;
  logic        DM_CS;
  logic        DM_R;
  logic        DM_W;
  logic [31:0] addr;
  logic [31:0] dm_in;
  logic [31:0] dm_out;

  modport master (output DM_CS, DM_R, DM_W, addr, dm_in, input dm_out);
  modport slave  (input DM_CS, DM_R, DM_W, addr, dm_in, output dm_out);
endinterface

// File: rtl/data_mem_resp.sv
// data_mem_resp: word-organised data RAM for the CPU DM port, with
// alignment/range checking and an optional MMIO window.
//   clk     : clock, rising edge
//   rst     : asynchronous active-low reset
//   bus     : data_mem_resp_if.slave (DM_CS, DM_R, DM_W, addr, dm_in, dm_out)
//   led_out : LED register (0 when MMIO is compiled out)
//   err     : OR of the sticky STATUS bits, registered
// Optional feature macro: DATA_MEM_MMIO_EN (MMIO window at 0xFFFF0000 with
// CYCLE, RDCNT, WRCNT, LED, STATUS). Without it STATUS/err still exist but
// are not addressable; every 0xFFFF_xxxx address is out-of-range.
module data_mem_resp #(
  parameter int ADDR_W = 10,
  parameter int LED_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_resp_if.slave       bus,
  output logic [LED_W-1:0]     led_out,
  output logic                 err
);

  localparam int WORDS = 1 << ADDR_W;

  logic [31:0]       mem [WORDS];
  logic [ADDR_W-1:0] widx;
  logic [31:0]       ram_rdata;

  logic        access, misal, in_ram, mmio_hit, ok;
  logic        ram_we, ram_rd;
  logic [31:0] mmio_rdata;
  logic [1:0]  status_q, status_d, err_set, w1c;

  assign access    = bus.DM_CS & (bus.DM_R | bus.DM_W);
  assign misal     = bus.addr[1:0] != 2'b00;
  assign in_ram    = bus.addr[31:ADDR_W+2] == '0;
  assign widx      = bus.addr[ADDR_W+1:2];
  assign ram_rdata = mem[widx];

  // Misaligned wins over out-of-range; a suppressed access touches nothing.
  assign ok      = access & ~misal & (in_ram | mmio_hit);
  assign err_set = {access & ~misal & ~(in_ram | mmio_hit), access & misal};
  // R+W together counts as a write only.
  assign ram_we  = ok & in_ram & bus.DM_W;
  assign ram_rd  = ok & in_ram & bus.DM_R & ~bus.DM_W;

  // Combinational read; with R+W this naturally yields pre-write contents.
  always_comb begin
    bus.dm_out = '0;
    if (ok && bus.DM_R)
      bus.dm_out = in_ram ? ram_rdata : mmio_rdata;
  end

  // No reset on the array: contents survive reset. A write presented while
  // rst is low is dropped.
  always_ff @(posedge clk) begin
    if (rst && ram_we)
      mem[widx] <= bus.dm_in;
  end

`ifdef DATA_MEM_MMIO_EN
  logic [31:0]      cycle_q, rdcnt_q, wrcnt_q;
  logic [LED_W-1:0] led_q;
  logic             pg_hit;
  logic             sel_cyc, sel_rd, sel_wr, sel_led, sel_st;
  logic             mmio_we;

  assign pg_hit   = bus.addr[31:16] == 16'hFFFF;
  assign sel_cyc  = pg_hit && bus.addr[15:0] == 16'h0000;
  assign sel_rd   = pg_hit && bus.addr[15:0] == 16'h0004;
  assign sel_wr   = pg_hit && bus.addr[15:0] == 16'h0008;
  assign sel_led  = pg_hit && bus.addr[15:0] == 16'h000C;
  assign sel_st   = pg_hit && bus.addr[15:0] == 16'h0010;
  assign mmio_hit = sel_cyc | sel_rd | sel_wr | sel_led | sel_st;
  assign mmio_we  = ok & ~in_ram & bus.DM_W;
  assign w1c      = (mmio_we & sel_st) ? bus.dm_in[1:0] : 2'b00;
  assign led_out  = led_q;

  always_comb begin
    mmio_rdata = '0;
    if (sel_cyc) mmio_rdata = cycle_q;
    if (sel_rd)  mmio_rdata = rdcnt_q;
    if (sel_wr)  mmio_rdata = wrcnt_q;
    if (sel_led) mmio_rdata = 32'(led_q);
    if (sel_st)  mmio_rdata = {30'd0, status_q};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_q <= '0;
      rdcnt_q <= '0;
      wrcnt_q <= '0;
      led_q   <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (ram_rd && rdcnt_q != '1) rdcnt_q <= rdcnt_q + 32'd1;
      if (ram_we && wrcnt_q != '1) wrcnt_q <= wrcnt_q + 32'd1;
      if (mmio_we && sel_led)      led_q   <= bus.dm_in[LED_W-1:0];
    end
  end
`else
  assign mmio_hit   = 1'b0;
  assign mmio_rdata = '0;
  assign w1c        = 2'b00;
  assign led_out    = '0;
`endif

  // A set and a clear of the same bit in one cycle resolve to set.
  assign status_d = (status_q & ~w1c) | err_set;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) status_q <= '0;
    else      status_q <= status_d;
  end

  assign err = |status_q;

endmodule

// File: tb/tb_data_mem_resp.sv
module tb_data_mem_resp;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] led_out;
  logic        err;

  data_mem_resp_if bus();

  data_mem_resp #(.ADDR_W(10), .LED_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .led_out(led_out), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  // Present one access for one clock period; returns with combinational
  // outputs settled, before the next rising edge.
  task automatic drive(input logic cs, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.DM_CS = cs; bus.DM_R = r; bus.DM_W = w; bus.addr = a; bus.dm_in = d;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Pull reset low in the middle of a write cycle, then verify the write
  // was dropped and registers cleared.
  task automatic rst_mid_write(input logic [31:0] a, input logic [31:0] oldv,
                               input logic [31:0] newv);
    drive(1'b1, 1'b0, 1'b1, a, oldv);
    drive(1'b1, 1'b0, 1'b1, a, newv);
    rst = 1'b0;
    #1;
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_led", {16'd0, led_out}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
`ifdef DATA_MEM_MMIO_EN
    bus.DM_CS = 1'b1; bus.DM_R = 1'b1; bus.DM_W = 1'b0;
    bus.addr = 32'hFFFF_0000; bus.dm_in = 32'h0;
    #1;
    chk("rst_cycle", bus.dm_out, 32'h0);
`else
    bus.DM_CS = 1'b0; bus.DM_R = 1'b0; bus.DM_W = 1'b0;
`endif
    drive(1'b1, 1'b1, 1'b0, a, 32'h0);
    chk("rst_word_kept", bus.dm_out, oldv);
  endtask

  typedef struct {
    logic        cs, r, w;
    logic [31:0] a, d, exp_out;
    logic        exp_err;
  } vec_t;

  vec_t tv[14];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] c1, c2;
    tv[0]  = '{1'b1, 1'b0, 1'b1, 32'h010, 32'hDEADBEEF, 32'h0,        1'b0};
    tv[1]  = '{1'b1, 1'b1, 1'b0, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0};
    tv[2]  = '{1'b1, 1'b0, 1'b1, 32'h014, 32'h12345678, 32'h0,        1'b0};
    tv[3]  = '{1'b1, 1'b1, 1'b0, 32'h014, 32'h0,        32'h12345678, 1'b0};
    tv[4]  = '{1'b1, 1'b0, 1'b1, 32'h020, 32'h11,       32'h0,        1'b0};
    tv[5]  = '{1'b1, 1'b1, 1'b1, 32'h020, 32'h22,       32'h11,       1'b0};
    tv[6]  = '{1'b1, 1'b1, 1'b0, 32'h020, 32'h0,        32'h22,       1'b0};
    tv[7]  = '{1'b1, 1'b0, 1'b1, 32'h012, 32'hFFFFFFFF, 32'h0,        1'b0};
    tv[8]  = '{1'b1, 1'b1, 1'b0, 32'h010, 32'h0,        32'hDEADBEEF, 1'b1};
    tv[9]  = '{1'b1, 1'b0, 1'b1, 32'hFFC, 32'hAAAA5555, 32'h0,        1'b1};
    tv[10] = '{1'b1, 1'b1, 1'b0, 32'hFFC, 32'h0,        32'hAAAA5555, 1'b1};
    tv[11] = '{1'b0, 1'b1, 1'b1, 32'h010, 32'h0,        32'h0,        1'b1};
    tv[12] = '{1'b1, 1'b1, 1'b0, 32'h010, 32'h0,        32'hDEADBEEF, 1'b1};
    tv[13] = '{1'b1, 1'b0, 1'b0, 32'h010, 32'h0,        32'h0,        1'b1};

    bus.DM_CS = 1'b0; bus.DM_R = 1'b0; bus.DM_W = 1'b0;
    bus.addr = 32'h0; bus.dm_in = 32'h0;
    #1;
    chk("reset_err", {31'd0, err}, 32'd0);
    chk("reset_led", {16'd0, led_out}, 32'd0);
    chk("reset_dm_out", bus.dm_out, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 14; i++) begin
      drive(tv[i].cs, tv[i].r, tv[i].w, tv[i].a, tv[i].d);
      chk($sformatf("vec%0d_out", i), bus.dm_out, tv[i].exp_out);
      chk($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, tv[i].exp_err});
    end

`ifdef DATA_MEM_MMIO_EN
    drive(1'b1, 1'b1, 1'b0, 32'hFFFF_0010, 32'h0);
    chk("status_misal", bus.dm_out, 32'h1);
    drive(1'b1, 1'b1, 1'b0, 32'hFFFF_0004, 32'h0);
    chk("rdcnt", bus.dm_out, 32'd6);
    drive(1'b1, 1'b1, 1'b0, 32'hFFFF_0008, 32'h0);
    chk("wrcnt", bus.dm_out, 32'd5);
    drive(1'b1, 1'b0, 1'b1, 32'hFFFF_0010, 32'h1);
    idle();
    chk("w1c_err", {31'd0, err}, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 32'hFFFF_0010, 32'h0);
    chk("w1c_status", bus.dm_out, 32'h0);

    drive(1'b1, 1'b1, 1'b0, 32'h0000_1000, 32'h0);
    chk("oor_out", bus.dm_out, 32'h0);
    idle();
    chk("oor_err", {31'd0, err}, 32'd1);
    drive(1'b1, 1'b1, 1'b0, 32'hFFFF_0010, 32'h0);
    chk("oor_status", bus.dm_out, 32'h2);
    drive(1'b1, 1'b0, 1'b1, 32'hFFFF_0010, 32'h2);

    drive(1'b1, 1'b1, 1'b0, 32'hFFFF_0014, 32'h0);
    chk("unmapped_out", bus.dm_out, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'hFFFF_0010, 32'h0);
    chk("unmapped_status", bus.dm_out, 32'h2);
    drive(1'b1, 1'b0, 1'b1, 32'hFFFF_0010, 32'h2);

    drive(1'b1, 1'b1, 1'b0, 32'h0000_1001, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'hFFFF_0010, 32'h0);
    chk("misal_prio_status", bus.dm_out, 32'h1);
    drive(1'b1, 1'b0, 1'b1, 32'hFFFF_0010, 32'h1);

    drive(1'b1, 1'b0, 1'b1, 32'hFFFF_000C, 32'h0001A5A5);
    idle();
    chk("led_out", {16'd0, led_out}, 32'h0000A5A5);
    drive(1'b1, 1'b1, 1'b0, 32'hFFFF_000C, 32'h0);
    chk("led_read", bus.dm_out, 32'h0000A5A5);

    drive(1'b1, 1'b1, 1'b0, 32'hFFFF_0000, 32'h0);
    c1 = bus.dm_out;
    drive(1'b1, 1'b0, 1'b1, 32'hFFFF_0000, 32'h0);
    idle(); idle(); idle();
    drive(1'b1, 1'b1, 1'b0, 32'hFFFF_0000, 32'h0);
    c2 = bus.dm_out;
    chk("cycle_delta", c2 - c1, 32'd5);
    chk("ro_write_no_err", {31'd0, err}, 32'd0);

    drive(1'b1, 1'b1, 1'b0, 32'hFFFF_0004, 32'h0);
    chk("rdcnt_mmio_uncounted", bus.dm_out, 32'd6);

    rst_mid_write(32'h30, 32'h55, 32'h99);
    drive(1'b1, 1'b1, 1'b0, 32'hFFFF_0008, 32'h0);
    chk("wrcnt_after_rst", bus.dm_out, 32'd0);
`else
    rst_mid_write(32'h30, 32'h55, 32'h99);
    drive(1'b1, 1'b1, 1'b0, 32'h0000_1000, 32'h0);
    chk("oor_out", bus.dm_out, 32'h0);
    idle();
    chk("oor_err", {31'd0, err}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rst2_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'hFFFF_0000, 32'h0);
    chk("nommio_out", bus.dm_out, 32'h0);
    idle();
    chk("nommio_err", {31'd0, err}, 32'd1);
    drive(1'b1, 1'b0, 1'b1, 32'hFFFF_000C, 32'h0001A5A5);
    idle();
    chk("nommio_led", {16'd0, led_out}, 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/data_mem_resp.md
# data_mem_resp

Data-memory responder for the single-cycle CPU's DM port. It serves the `DM_CS`/`DM_R`/`DM_W`/`addr`/`dm_in`/`dm_out` interface with a word-organised RAM that reads combinationally and writes synchronously. It checks every access for alignment and range. An optional memory-mapped I/O window exposes a cycle counter, access counters, an LED register and a sticky status register. It sits beside the CPU in the top level, opposite the CPU's data-port initiator.

## Interface
- `ADDR_W`, 10: RAM word-index width; RAM holds 2^ADDR_W 32-bit words.
- `LED_W`, 16: width of LED register and `led_out`.
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `DM_CS` in 1: access select; no effect on state when low.
- `DM_R` in 1: read request.
- `DM_W` in 1: write request.
- `addr` in 32: byte address from the CPU ALU.
- `dm_in` in 32: write data from the CPU.
- `dm_out` out 32: read data to the CPU, combinational.
- `led_out` out LED_W: LED register value.
- `err` out 1: OR of the STATUS sticky bits.

## Operation
- Decode: access = `DM_CS & (DM_R | DM_W)`.
- RAM region: `addr[31:ADDR_W+2] == 0`. The word index is `addr[ADDR_W+1:2]`.
- MMIO region: `addr[31:16] == 16'hFFFF`, only when the macro is defined. Any other address is out-of-range.
- Misaligned: `addr[1:0] != 0`. The access is suppressed: no write, no counter update, `dm_out = 0`, and STATUS bit0 is set.
- Out-of-range, including unmapped MMIO offsets: the access is suppressed, `dm_out = 0`, and STATUS bit1 is set. Misaligned takes priority; only bit0 is set when both conditions hold.
- Read: `dm_out` = addressed word in the same cycle. `dm_out = 0` when there is no valid read.
- Write: the RAM word is replaced by `dm_in` at the next rising edge. Whole words only.
- `DM_R` and `DM_W` both high: the write is performed and counted as a write only. `dm_out` shows the pre-write contents (read-before-write).
- MMIO map, offsets from 0xFFFF0000:
  - 0x00 CYCLE, RO: increments every cycle and wraps from FFFFFFFF to 0.
  - 0x04 RDCNT, RO: valid RAM reads; saturates at FFFFFFFF.
  - 0x08 WRCNT, RO: valid RAM writes; saturates at FFFFFFFF.
  - 0x0C LED, RW: takes `dm_in[LED_W-1:0]`; upper bits read as 0.
  - 0x10 STATUS, W1C: bit0 misaligned, bit1 out-of-range; other bits read 0.
- Writes to RO registers are ignored and are not errors. MMIO accesses do not change RDCNT or WRCNT.
- STATUS: an error set and a W1C clear of the same bit in the same cycle resolve to set.

## Timing
- Reset values: CYCLE, RDCNT, WRCNT, LED and STATUS are 0; `led_out = 0`, `err = 0`. `dm_out` is 0 when no valid read is presented.
- RAM contents are not initialised or cleared by reset.
- Read latency: 0 cycles (combinational). Write latency: 1 edge.
- Read-after-write to the same word in the next cycle returns the new data. There is no same-cycle forwarding.
- CYCLE read returns the value before this cycle's increment. Counter reads likewise return pre-update values.
- `err` is registered and asserts the cycle after the faulting access.
- `rst` asserted mid-access: all registers clear immediately and the pending write is dropped. There is no activity while `rst` is low.

## Configuration
- `DATA_MEM_MMIO_EN` defined: MMIO window, counters, LED register and `led_out` driving are present.
- Undefined: every 0xFFFF_xxxx address is out-of-range (sets STATUS bit1, reads 0). `led_out` is tied to 0. CYCLE, RDCNT and WRCNT logic is removed. STATUS and `err` remain.

## Test plan
- Write 0xDEADBEEF to 0x00000010, then read 0x00000010 next cycle → `dm_out = 0xDEADBEEF`; WRCNT = 1, RDCNT = 1.
- Write to 0x00000012 → RAM is unchanged, `err` = 1 the next cycle, STATUS reads 0x1. Writing 0x1 to 0xFFFF0010 → STATUS = 0, `err` = 0.
- Read 0x00001000 with ADDR_W = 10 → `dm_out = 0`, STATUS bit1 = 1. With the macro undefined, a read of 0xFFFF0000 gives the same result.
- Store 0x0001A5A5 to 0xFFFF000C → `led_out = 0xA5A5`, and a read returns 0x0000A5A5. Store to 0xFFFF0000 → CYCLE is unaffected.
- Same-cycle `DM_R = DM_W = 1` at 0x20 holding 0x11, `dm_in = 0x22` → `dm_out = 0x11` that cycle, 0x22 on the next read, WRCNT +1, RDCNT unchanged.
- Read CYCLE, wait 5 cycles, read again → difference 5. Pulse `rst` low mid-write → CYCLE = 0 and the target word is unchanged.
